// File: rtl/apb_gpio_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | apb_gpio_arbiter : two-requester round-robin APB front end for one slave |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module apb_gpio_arbiter #(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      HCLK,
  input  logic                      HRESETn,

  input  logic [APB_ADDR_WIDTH-1:0] m0_paddr,
  input  logic [31:0]               m0_pwdata,
  input  logic                      m0_pwrite,
  input  logic                      m0_psel,
  input  logic                      m0_penable,
  output logic [31:0]               m0_prdata,
  output logic                      m0_pready,
  output logic                      m0_pslverr,

  input  logic [APB_ADDR_WIDTH-1:0] m1_paddr,
  input  logic [31:0]               m1_pwdata,
  input  logic                      m1_pwrite,
  input  logic                      m1_psel,
  input  logic                      m1_penable,
  output logic [31:0]               m1_prdata,
  output logic                      m1_pready,
  output logic                      m1_pslverr,

  output logic [APB_ADDR_WIDTH-1:0] PADDR,
  output logic [31:0]               PWDATA,
  output logic                      PWRITE,
  output logic                      PSEL,
  output logic                      PENABLE,
  input  logic [31:0]               PRDATA,
  input  logic                      PREADY,
  input  logic                      PSLVERR,

  output logic [1:0]                grant
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  localparam logic [7:0] C_TIMEOUT = 8'(TIMEOUT_CYCLES);

  state_t                    state_q, state_d;
  logic                      owner_q, owner_d;
  logic                      last_q, last_d;
  logic [7:0]                wait_cnt_q, wait_cnt_d;
  logic [APB_ADDR_WIDTH-1:0] paddr_q, paddr_d;
  logic [31:0]               pwdata_q, pwdata_d;
  logic                      pwrite_q, pwrite_d;

  logic                      req_any;
  logic                      pick;
  logic                      done;
  logic [31:0]               rsp_data;
  logic                      rsp_err;

  // The requesters' access-phase strobe carries no information for arbitration.
  logic unused_penable;
  assign unused_penable = m0_penable ^ m1_penable;

  always_comb begin
    req_any = m0_psel | m1_psel;
    // On a tie the requester not served last wins; otherwise whoever asks.
    if (m0_psel && m1_psel) begin
      pick = ~last_q;
    end else begin
      pick = m1_psel;
    end

    done = (state_q == ACCESS) && (PREADY || (wait_cnt_q == C_TIMEOUT));

    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    wait_cnt_d = wait_cnt_q;
    paddr_d    = paddr_q;
    pwdata_d   = pwdata_q;
    pwrite_d   = pwrite_q;

    case (state_q)
      IDLE: begin
        if (req_any) begin
          state_d  = SETUP;
          owner_d  = pick;
          last_d   = pick;
          paddr_d  = pick ? m1_paddr  : m0_paddr;
          pwdata_d = pick ? m1_pwdata : m0_pwdata;
          pwrite_d = pick ? m1_pwrite : m0_pwrite;
        end
      end
      SETUP: begin
        state_d    = ACCESS;
        wait_cnt_d = 8'd0;
      end
      ACCESS: begin
        if (done) begin
          state_d    = IDLE;
          wait_cnt_d = 8'd0;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d    = IDLE;
        wait_cnt_d = 8'd0;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      wait_cnt_q <= 8'd0;
      paddr_q    <= '0;
      pwdata_q   <= 32'd0;
      pwrite_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      wait_cnt_q <= wait_cnt_d;
      paddr_q    <= paddr_d;
      pwdata_q   <= pwdata_d;
      pwrite_q   <= pwrite_d;
    end
  end

  assign PADDR   = paddr_q;
  assign PWDATA  = pwdata_q;
  assign PWRITE  = pwrite_q;
  assign PSEL    = (state_q != IDLE);
  assign PENABLE = (state_q == ACCESS);
  assign grant   = (state_q == IDLE) ? 2'b00 : (owner_q ? 2'b10 : 2'b01);

  // A timeout completes with an error and forces the read data to zero.
  assign rsp_data = PREADY ? PRDATA  : 32'd0;
  assign rsp_err  = PREADY ? PSLVERR : 1'b1;

  assign m0_pready  = done && !owner_q;
  assign m0_pslverr = m0_pready && rsp_err;
  assign m0_prdata  = m0_pready ? rsp_data : 32'd0;

  assign m1_pready  = done && owner_q;
  assign m1_pslverr = m1_pready && rsp_err;
  assign m1_prdata  = m1_pready ? rsp_data : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_apb_gpio_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_apb_gpio_arbiter : directed self-checking bench for apb_gpio_arbiter  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_apb_gpio_arbiter;

  logic        HCLK;
  logic        HRESETn;
  logic [11:0] m0_paddr, m1_paddr;
  logic [31:0] m0_pwdata, m1_pwdata;
  logic        m0_pwrite, m1_pwrite;
  logic        m0_psel, m1_psel;
  logic        m0_penable, m1_penable;
  logic [31:0] m0_prdata, m1_prdata;
  logic        m0_pready, m1_pready;
  logic        m0_pslverr, m1_pslverr;
  logic [11:0] PADDR;
  logic [31:0] PWDATA;
  logic        PWRITE, PSEL, PENABLE;
  logic [31:0] PRDATA;
  logic        PREADY, PSLVERR;
  logic [1:0]  grant;

  int n_checks = 0;
  int n_errors = 0;

  apb_gpio_arbiter #(
    .APB_ADDR_WIDTH(12),
    .TIMEOUT_CYCLES(16)
  ) u_dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .m0_paddr(m0_paddr), .m0_pwdata(m0_pwdata), .m0_pwrite(m0_pwrite),
    .m0_psel(m0_psel), .m0_penable(m0_penable), .m0_prdata(m0_prdata),
    .m0_pready(m0_pready), .m0_pslverr(m0_pslverr),
    .m1_paddr(m1_paddr), .m1_pwdata(m1_pwdata), .m1_pwrite(m1_pwrite),
    .m1_psel(m1_psel), .m1_penable(m1_penable), .m1_prdata(m1_prdata),
    .m1_pready(m1_pready), .m1_pslverr(m1_pslverr),
    .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE), .PSEL(PSEL),
    .PENABLE(PENABLE), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
    .grant(grant)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    int hits;
    int acc;
    logic seen;
    logic [31:0] rd;

    HRESETn = 1'b0;
    m0_paddr = '0; m0_pwdata = '0; m0_pwrite = 1'b0; m0_psel = 1'b0; m0_penable = 1'b0;
    m1_paddr = '0; m1_pwdata = '0; m1_pwrite = 1'b0; m1_psel = 1'b0; m1_penable = 1'b0;
    PRDATA = '0; PREADY = 1'b1; PSLVERR = 1'b0;

    repeat (2) @(negedge HCLK);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_psel", 32'(PSEL), 32'h0);
    check("rst_penable", 32'(PENABLE), 32'h0);
    check("rst_paddr", 32'(PADDR), 32'h0);
    check("rst_m0_pready", 32'(m0_pready), 32'h0);
    HRESETn = 1'b1;

    // Both request together after reset; both keep requesting for three grants.
    @(negedge HCLK);
    m0_paddr = 12'h004; m1_paddr = 12'h00C;
    m0_psel = 1'b1; m1_psel = 1'b1; PREADY = 1'b1;
    @(negedge HCLK); check("tie_c1_grant", 32'(grant), 32'h1);
    @(negedge HCLK); check("tie_c2_m0_pready", 32'(m0_pready), 32'h1);
                     check("tie_c2_m1_pready", 32'(m1_pready), 32'h0);
    @(negedge HCLK); check("tie_c3_idle_grant", 32'(grant), 32'h0);
    @(negedge HCLK); check("tie_c4_grant", 32'(grant), 32'h2);
                     check("tie_c4_paddr", 32'(PADDR), 32'h00C);
    @(negedge HCLK); check("tie_c5_m1_pready", 32'(m1_pready), 32'h1);
                     check("tie_c5_m0_pready", 32'(m0_pready), 32'h0);
    @(negedge HCLK); check("tie_c6_idle_psel", 32'(PSEL), 32'h0);
    @(negedge HCLK); check("tie_c7_grant", 32'(grant), 32'h1);
    m0_psel = 1'b0; m1_psel = 1'b0;
    @(negedge HCLK); check("drop_c8_m0_pready", 32'(m0_pready), 32'h1);
    @(negedge HCLK); check("drop_c9_grant", 32'(grant), 32'h0);
    @(negedge HCLK); check("drop_c10_psel", 32'(PSEL), 32'h0);

    // m0 write, zero-wait slave.
    m0_paddr = 12'h008; m0_pwdata = 32'hA5A5_0001; m0_pwrite = 1'b1; m0_psel = 1'b1;
    @(negedge HCLK);
    check("wr_c1_psel", 32'(PSEL), 32'h1);
    check("wr_c1_penable", 32'(PENABLE), 32'h0);
    check("wr_c1_grant", 32'(grant), 32'h1);
    check("wr_c1_paddr", 32'(PADDR), 32'h008);
    check("wr_c1_pwdata", PWDATA, 32'hA5A5_0001);
    check("wr_c1_pwrite", 32'(PWRITE), 32'h1);
    m0_psel = 1'b0; m0_paddr = 12'hFFF; m0_pwdata = 32'h0; m0_pwrite = 1'b0;
    @(negedge HCLK);
    check("wr_c2_penable", 32'(PENABLE), 32'h1);
    check("wr_c2_paddr_held", 32'(PADDR), 32'h008);
    check("wr_c2_pwrite_held", 32'(PWRITE), 32'h1);
    check("wr_c2_m0_pready", 32'(m0_pready), 32'h1);
    check("wr_c2_m0_pslverr", 32'(m0_pslverr), 32'h0);
    @(negedge HCLK);
    check("wr_c3_psel", 32'(PSEL), 32'h0);
    check("wr_c3_m0_pready", 32'(m0_pready), 32'h0);

    // m1 read, single access phase.
    m1_paddr = 12'h018; m1_pwrite = 1'b0; m1_psel = 1'b1; PRDATA = 32'h0000_0004;
    hits = 0; rd = 32'hFFFF_FFFF;
    for (int i = 1; i <= 5; i++) begin
      @(negedge HCLK);
      if (i == 1) m1_psel = 1'b0;
      if (PSEL && PENABLE) hits++;
      if (m1_pready) rd = m1_prdata;
      if (PSEL && PENABLE) check("rd_m0_prdata_zero", m0_prdata, 32'h0);
    end
    check("rd_access_cycles", 32'(hits), 32'd1);
    check("rd_m1_prdata", rd, 32'h0000_0004);

    // m1 with two wait states and a slave error.
    m1_psel = 1'b1; PREADY = 1'b0; PSLVERR = 1'b1; PRDATA = 32'h0000_0055;
    @(negedge HCLK); m1_psel = 1'b0;
    @(negedge HCLK); check("ws_c2_m1_pready", 32'(m1_pready), 32'h0);
    @(negedge HCLK); check("ws_c3_m1_pready", 32'(m1_pready), 32'h0);
    PREADY = 1'b1;
    #1;
    check("ws_c3_ready_pready", 32'(m1_pready), 32'h1);
    check("ws_c3_pslverr", 32'(m1_pslverr), 32'h1);
    check("ws_c3_prdata", m1_prdata, 32'h0000_0055);
    @(negedge HCLK); check("ws_c4_psel", 32'(PSEL), 32'h0);
    PSLVERR = 1'b0;

    // m0 against a slave that never answers.
    m0_psel = 1'b1; PREADY = 1'b0; PRDATA = 32'hDEAD_BEEF;
    acc = 0; seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge HCLK);
      if (i == 0) m0_psel = 1'b0;
      if (PSEL && PENABLE) acc++;
      if (m0_pready) begin
        seen = 1'b1;
        check("to_pslverr", 32'(m0_pslverr), 32'h1);
        check("to_prdata", m0_prdata, 32'h0);
      end
    end
    check("to_strobe_seen", 32'(seen), 32'h1);
    check("to_access_cycles", 32'(acc), 32'd17);
    @(negedge HCLK); check("to_after_psel", 32'(PSEL), 32'h0);

    // Reset in the middle of an access phase.
    m0_paddr = 12'h020; m0_psel = 1'b1;
    @(negedge HCLK); m0_psel = 1'b0;
    @(negedge HCLK); check("rm_penable", 32'(PENABLE), 32'h1);
    #1 HRESETn = 1'b0;
    PREADY = 1'b1;
    #1;
    check("rm_psel", 32'(PSEL), 32'h0);
    check("rm_penable_rst", 32'(PENABLE), 32'h0);
    check("rm_grant", 32'(grant), 32'h0);
    check("rm_paddr", 32'(PADDR), 32'h0);
    check("rm_m0_pready", 32'(m0_pready), 32'h0);
    @(negedge HCLK);
    check("rm_hold_m0_pready", 32'(m0_pready), 32'h0);
    HRESETn = 1'b1;
    m1_paddr = 12'h010; m1_psel = 1'b1;
    @(negedge HCLK); check("post_rst_grant", 32'(grant), 32'h2);
    m1_psel = 1'b0;
    @(negedge HCLK); check("post_rst_m1_pready", 32'(m1_pready), 32'h1);
    @(negedge HCLK); check("post_rst_idle", 32'(grant), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/apb_gpio_arbiter.md
APB_GPIO_ARBITER -- requirements
Module: apb_gpio_arbiter

Interface
REQ-001 SHALL have parameter APB_ADDR_WIDTH, default 12, giving the width of every address port.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16, giving the maximum slave wait cycles in ACCESS before forced error completion (legal range 1..255).
REQ-003 SHALL have port HCLK  in  1  sole clock; one clock, all state on rising edge.
REQ-004 SHALL have port HRESETn  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port mN_paddr (N=0,1)  in  APB_ADDR_WIDTH  requester N address.
REQ-006 SHALL have port mN_pwdata  in  32  requester N write data.
REQ-007 SHALL have port mN_pwrite  in  1  requester N write=1/read=0.
REQ-008 SHALL have port mN_psel  in  1  requester N transfer request.
REQ-009 SHALL have port mN_penable  in  1  requester N access phase (ignored by arbitration).
REQ-010 SHALL have port mN_prdata  out  32  read data returned to requester N.
REQ-011 SHALL have port mN_pready  out  1  completion strobe to requester N.
REQ-012 SHALL have port mN_pslverr  out  1  error flag to requester N, valid with mN_pready.
REQ-013 SHALL have ports PADDR out APB_ADDR_WIDTH, PWDATA out 32, PWRITE out 1, PSEL out 1, PENABLE out 1: APB master side to the GPIO slave.
REQ-014 SHALL have ports PRDATA in 32, PREADY in 1, PSLVERR in 1: GPIO slave response.
REQ-015 SHALL have port grant  out  2  one-hot current owner, 2'b00 when idle.

Function
REQ-016 SHALL implement FSM IDLE -> SETUP -> ACCESS -> IDLE, one state register.
REQ-017 In IDLE with any mN_psel=1, SHALL select owner and move to SETUP next edge; no request: stay IDLE.
REQ-018 Selection SHALL be round-robin: single requester wins; both requesting -> requester not granted last wins; last-granted pointer updates at grant.
REQ-019 At grant SHALL register owner's paddr/pwdata/pwrite into PADDR/PWDATA/PWRITE, held constant through SETUP and ACCESS.
REQ-020 SETUP: PSEL=1, PENABLE=0, exactly one cycle, then ACCESS.
REQ-021 ACCESS: PSEL=1, PENABLE=1; held while PREADY=0; one wait-cycle counter (8 bits) increments per PREADY=0 cycle.
REQ-022 ACCESS with PREADY=1: owner's mN_pready=1, mN_prdata=PRDATA, mN_pslverr=PSLVERR combinationally that cycle; next state IDLE.
REQ-023 ACCESS with PREADY=0 and counter==TIMEOUT_CYCLES: owner's mN_pready=1, mN_pslverr=1, mN_prdata=0; next state IDLE; slave transfer dropped.
REQ-024 PSEL&PENABLE SHALL be high for exactly the cycles of one ACCESS per granted transfer (no duplicated access; read-to-clear registers cleared once).
REQ-025 Non-owner and idle mN_pready, mN_pslverr SHALL be 0 and mN_prdata SHALL be 0; PSEL, PENABLE SHALL be 0 in IDLE.
REQ-026 Owner dropping mN_psel after grant: transfer still completes on slave; response strobe still issued to that requester and ignored.
REQ-027 Minimum latency: request at cycle 0 -> SETUP cycle 1 -> ACCESS cycle 2, mN_pready at cycle 2 with zero-wait slave.
REQ-028 Back-to-back: always one IDLE cycle between transfers; pending requester granted in that IDLE cycle.
REQ-029 grant SHALL be one-hot of owner in SETUP and ACCESS, 2'b00 in IDLE.

Reset
REQ-030 HRESETn low SHALL asynchronously force IDLE, counter 0, PADDR/PWDATA 0, PWRITE/PSEL/PENABLE 0, grant 2'b00, last-granted pointer = requester 1 (first tie goes to requester 0).
REQ-031 All mN_* outputs SHALL be 0 during reset; reset mid-transfer aborts without any mN_pready strobe.

Verification
REQ-032 m0 write 0x08 data 0xA5A5_0001, PREADY=1 -> slave PSEL cycle 1, PENABLE cycle 2, m0_pready cycle 2, grant=01.
REQ-033 m0 and m1 request same cycle after reset -> m0 served first, m1 granted in next IDLE; repeat -> m1 then m0 alternate.
REQ-034 m1 read 0x18, PRDATA=0x0000_0004 -> m1_prdata=0x0000_0004 with m1_pready; PSEL&PENABLE high exactly 1 cycle.
REQ-035 PREADY held 0, TIMEOUT_CYCLES=16 -> owner pready=1, pslverr=1, prdata=0 after 16 wait cycles; FSM IDLE next cycle.
REQ-036 HRESETn low during ACCESS -> all outputs 0 immediately, no mN_pready; post-reset request from m1 alone granted normally.
